// File: rtl/sat_accum_adder.sv
// sat_accum_adder: unsigned adder with optional saturation and a running
// accumulator, behind a single-entry valid/ready output register.
//
// Handshake: an operand transfer happens on a rising edge where
// in_valid && in_ready; a result transfer happens where out_valid && out_ready.
// in_ready is combinational (!out_valid || out_ready), so a consumed result can
// be replaced by a new one in the same cycle and throughput is one per cycle.
// Once out_valid is high, result/carry/sat are held until the transfer.
module sat_accum_adder #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 carry,
    output logic                 sat,
    output logic [CNT_WIDTH-1:0] txn_count
);

    // mode[1] selects accumulate, mode[0] selects saturate
    localparam logic [WIDTH-1:0]     MAX_VAL = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_result;
    logic                 r_carry;
    logic                 r_sat;
    logic                 r_out_valid;
    logic [CNT_WIDTH-1:0] r_txn_count;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_acc_term;
    logic [WIDTH+1:0]     w_acc_ext;
    logic [WIDTH+1:0]     w_sum;
    logic                 w_over;
    logic                 w_clamp;
    logic [WIDTH-1:0]     w_res;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A same-cycle clear zeroes the accumulator before it joins the sum.
    assign w_acc_term = clear ? '0 : r_acc;
    assign w_acc_ext  = mode[1] ? {2'b00, w_acc_term} : {(WIDTH+2){1'b0}};

    // Two guard bits hold acc+a+b without truncation.
    assign w_sum   = {2'b00, a} + {2'b00, b} + w_acc_ext;
    assign w_over  = |w_sum[WIDTH+1:WIDTH];
    assign w_clamp = mode[0] && w_over;
    assign w_res   = w_clamp ? MAX_VAL : w_sum[WIDTH-1:0];

    // Result register: loaded only on accept, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_sat    <= 1'b0;
        end else if (w_accept) begin
            r_result <= w_res;
            r_carry  <= w_over;
            r_sat    <= w_clamp;
        end
    end

    // Output valid: set by accept, dropped by a transfer with no new accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Accumulator: accumulate modes store the produced result; clear zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept && mode[1]) begin
            r_acc <= w_res;
        end else if (clear) begin
            r_acc <= '0;
        end
    end

    // Transaction counter: one step per accept, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txn_count <= '0;
        end else if (w_accept) begin
            r_txn_count <= r_txn_count + CNT_ONE;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign sat       = r_sat;
    assign txn_count = r_txn_count;

endmodule

// File: doc/sat_accum_adder.md
SAT_ACCUM_ADDER -- requirements
Module: sat_accum_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (2..32).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, transaction-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand transfer request.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-008 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-009 SHALL have port mode  input  2  00 ADD, 01 SAT, 10 ACC, 11 ACC_SAT; sampled with operands.
REQ-010 SHALL have port clear  input  1  zero accumulator (level, sampled every cycle).
REQ-011 SHALL have port out_valid  output  1  result register holds unconsumed result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port result  output  WIDTH  registered result.
REQ-014 SHALL have port carry  output  1  unsaturated sum exceeded 2^WIDTH-1 for this result.
REQ-015 SHALL have port sat  output  1  result was clamped (SAT/ACC_SAT only).
REQ-016 SHALL have port txn_count  output  CNT_WIDTH  number of accepted transactions, wrapping.

Function
REQ-017 Accept occurs in a cycle with in_valid && in_ready; output transfer occurs in a cycle with out_valid && out_ready.
REQ-018 in_ready SHALL equal !out_valid || out_ready (combinational; single output stage, full throughput).
REQ-019 Latency: result/carry/sat/out_valid SHALL update on the edge ending the accept cycle (1 cycle).
REQ-020 Internal sum SHALL be WIDTH+2 bits wide; no intermediate truncation.
REQ-021 ADD: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of a+b; sat = 0.
REQ-022 SAT: result = min(a+b, 2^WIDTH-1); carry as ADD; sat = carry.
REQ-023 ACC: s = acc+a+b; result = s mod 2^WIDTH; acc <= result; carry = (s > 2^WIDTH-1); sat = 0.
REQ-024 ACC_SAT: s = acc+a+b; result = min(s, 2^WIDTH-1); acc <= result; carry = (s > 2^WIDTH-1); sat = carry.
REQ-025 ADD/SAT accepts SHALL NOT modify acc.
REQ-026 clear without accept SHALL set acc to 0 next edge; result/out_valid unaffected.
REQ-027 clear in the same cycle as an ACC/ACC_SAT accept: acc term treated as 0 (clear first, then add).
REQ-028 out_valid: set on accept; cleared on output transfer without simultaneous accept; stays 1 on simultaneous transfer+accept with new result loaded.
REQ-029 While out_valid && !out_ready: result, carry, sat SHALL hold stable; no accept occurs.
REQ-030 txn_count SHALL increment by 1 per accept, wrapping 2^CNT_WIDTH-1 -> 0.
REQ-031 Operands, mode, clear SHALL be ignored in cycles without accept, except clear per REQ-026.

Reset
REQ-032 rst high at an edge SHALL set acc=0, result=0, carry=0, sat=0, out_valid=0, txn_count=0, overriding any accept or clear that cycle.
REQ-033 in_ready SHALL be 1 in the cycle after reset deasserts; a pending unconsumed result is discarded by reset.

Verification
REQ-034 WIDTH=8, ADD a=200 b=100, out_ready=1 -> next cycle result=44, carry=1, sat=0, out_valid=1.
REQ-035 SAT a=200 b=100 -> result=255, carry=1, sat=1; SAT a=3 b=4 -> result=7, carry=0, sat=0.
REQ-036 clear, then ACC (10,20), (30,40), (100,100) back-to-back -> results 30, 100, 44 with carry=1 on third; ACC_SAT from acc=44 with (250,0) -> 255, sat=1.
REQ-037 Backpressure: out_ready=0 after one accept -> in_ready=0, result held stable 5 cycles; out_ready=1 with in_valid=1 -> transfer and new accept same cycle, out_valid stays 1.
REQ-038 clear with ACC accept (5,6) when acc=50 -> result=11; rst asserted mid-stream with out_valid=1 -> all outputs 0 next cycle, txn_count=0.
REQ-039 CNT_WIDTH=4: 17 accepts from reset -> txn_count=1.
